// File: rtl/decryption_demux_if.sv
// Bundle between the upstream source, the demux and the three decryptors.
// The slave side is the demux; the master side drives it.
interface decryption_demux_if #(
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0] data_i;
  logic               valid_i;
  logic [1:0]         select_i;
  logic               busy0_i;
  logic               busy1_i;
  logic               busy2_i;
  logic [D_WIDTH-1:0] data0_o;
  logic [D_WIDTH-1:0] data1_o;
  logic [D_WIDTH-1:0] data2_o;
  logic               valid0_o;
  logic               valid1_o;
  logic               valid2_o;
  logic               busy_o;
  logic               err_o;

  modport slave (
    input  data_i, valid_i, select_i,
    input  busy0_i, busy1_i, busy2_i,
    output data0_o, data1_o, data2_o,
    output valid0_o, valid1_o, valid2_o,
    output busy_o, err_o
  );

  modport master (
    output data_i, valid_i, select_i,
    output busy0_i, busy1_i, busy2_i,
    input  data0_o, data1_o, data2_o,
    input  valid0_o, valid1_o, valid2_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/decryption_demux.sv
// In-order FIFO demux steering {select,data} entries to three decryptors;
// a busy head channel stalls everything behind it.
module decryption_demux #(
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  decryption_demux_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [D_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [1:0]         r_mem_sel  [FIFO_DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [AW:0]        r_count;
  logic [2:0]         r_valid;
  logic [D_WIDTH-1:0] r_data0;
  logic [D_WIDTH-1:0] r_data1;
  logic [D_WIDTH-1:0] r_data2;
  logic               r_err;

  logic               w_full;
  logic               w_illegal;
  logic               w_push;
  logic               w_pop;
  logic [1:0]         w_head_sel;
  logic [D_WIDTH-1:0] w_head_data;
  logic [3:0]         w_busy;

  // Select 3 never enters the FIFO; treating it as busy keeps the index safe.
  assign w_busy      = {1'b1, bus.busy2_i, bus.busy1_i, bus.busy0_i};
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_illegal   = bus.valid_i && (bus.select_i == 2'd3);
  assign w_push      = bus.valid_i && !w_full && (bus.select_i != 2'd3);
  assign w_head_sel  = r_mem_sel[r_rptr];
  assign w_head_data = r_mem_data[r_rptr];
  assign w_pop       = (r_count != '0) && !w_busy[w_head_sel];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= bus.data_i;
      r_mem_sel[r_wptr]  <= bus.select_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= '0;
      r_err   <= w_illegal;
      if (w_pop) begin
        unique case (1'b1)
          (w_head_sel == 2'd0): begin
            r_valid[0] <= 1'b1;
            r_data0    <= w_head_data;
          end
          (w_head_sel == 2'd1): begin
            r_valid[1] <= 1'b1;
            r_data1    <= w_head_data;
          end
          (w_head_sel == 2'd2): begin
            r_valid[2] <= 1'b1;
            r_data2    <= w_head_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data0_o  = r_data0;
  assign bus.data1_o  = r_data1;
  assign bus.data2_o  = r_data2;
  assign bus.valid0_o = r_valid[0];
  assign bus.valid1_o = r_valid[1];
  assign bus.valid2_o = r_valid[2];
  assign bus.err_o    = r_err;
  assign bus.busy_o   = w_full;
endmodule

// File: tb/tb_decryption_demux.sv
// Bench: directed scenarios with literal expectations plus random
// traffic against a queue-based model of the demux.
module tb_decryption_demux;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  bit   cmp_en;

  decryption_demux_if #(.D_WIDTH(DW)) bus ();

  decryption_demux #(
    .D_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a plain arrival-order queue; head leaves when its channel is idle.
  int       q_sel[$];
  int       q_dat[$];
  bit [2:0] m_valid;
  bit [7:0] m_data[3];
  bit       m_err;

  initial begin
    int  hs;
    bit  full;
    bit [2:0] bz;
    m_valid = '0;
    m_err   = 1'b0;
    foreach (m_data[k]) m_data[k] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_sel.delete();
        q_dat.delete();
        m_valid = '0;
        m_err   = 1'b0;
        foreach (m_data[k]) m_data[k] = '0;
      end else begin
        full    = (q_sel.size() == DEPTH);
        bz      = {bus.busy2_i, bus.busy1_i, bus.busy0_i};
        m_valid = '0;
        m_err   = bus.valid_i && (bus.select_i == 2'd3);
        if (q_sel.size() > 0) begin
          hs = q_sel[0];
          if (!bz[hs]) begin
            m_valid[hs] = 1'b1;
            m_data[hs]  = 8'(q_dat[0]);
            void'(q_sel.pop_front());
            void'(q_dat.pop_front());
          end
        end
        if (bus.valid_i && bus.select_i != 2'd3 && !full) begin
          q_sel.push_back(int'(bus.select_i));
          q_dat.push_back(int'(bus.data_i));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid0", 32'(bus.valid0_o), 32'(m_valid[0]));
      chk("valid1", 32'(bus.valid1_o), 32'(m_valid[1]));
      chk("valid2", 32'(bus.valid2_o), 32'(m_valid[2]));
      chk("data0", 32'(bus.data0_o), 32'(m_data[0]));
      chk("data1", 32'(bus.data1_o), 32'(m_data[1]));
      chk("data2", 32'(bus.data2_o), 32'(m_data[2]));
      chk("err", 32'(bus.err_o), 32'(m_err));
      chk("busy_o", 32'(bus.busy_o), 32'(q_sel.size() == DEPTH));
    end
  end

  task automatic drive(input bit v, input bit [1:0] s, input bit [7:0] d);
    bus.valid_i  = v;
    bus.select_i = s;
    bus.data_i   = d;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    drive(0, 0, 0);
    bus.busy0_i = 0;
    bus.busy1_i = 0;
    bus.busy2_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_valid0", 32'(bus.valid0_o), 0);
    chk("rst_data0", 32'(bus.data0_o), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // single byte, two-edge latency
    @(negedge clk); drive(1, 0, 8'h41);
    @(negedge clk); drive(0, 0, 0);
    @(negedge clk);
    chk("s1_data0", 32'(bus.data0_o), 32'h41);
    chk("s1_valid0", 32'(bus.valid0_o), 1);
    chk("s1_valid1", 32'(bus.valid1_o), 0);
    chk("s1_valid2", 32'(bus.valid2_o), 0);
    @(negedge clk);
    chk("s1_valid0_off", 32'(bus.valid0_o), 0);
    chk("s1_data0_hold", 32'(bus.data0_o), 32'h41);

    // fill behind busy channel 1, fifth byte dropped
    @(negedge clk); bus.busy1_i = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 4) chk("s2_full", 32'(bus.busy_o), 1);
      drive(1, 1, 8'(8'h10 + i));
    end
    @(negedge clk); drive(0, 0, 0); bus.busy1_i = 0;
    chk("s2_still_full", 32'(bus.busy_o), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s2_valid1", 32'(bus.valid1_o), 1);
      chk("s2_data1", 32'(bus.data1_o), 32'(8'h10 + i));
    end
    @(negedge clk);
    chk("s2_drained", 32'(bus.valid1_o), 0);
    chk("s2_not_full", 32'(bus.busy_o), 0);

    // illegal select
    @(negedge clk); drive(1, 3, 8'h22);
    @(negedge clk); drive(0, 0, 0);
    chk("s3_err", 32'(bus.err_o), 1);
    chk("s3_novalid", 32'({bus.valid0_o, bus.valid1_o, bus.valid2_o}), 0);
    chk("s3_busy", 32'(bus.busy_o), 0);
    @(negedge clk);
    chk("s3_err_off", 32'(bus.err_o), 0);
    chk("s3_no_pop", 32'(bus.valid2_o), 0);

    // head-of-line blocking
    @(negedge clk); bus.busy0_i = 1; drive(1, 0, 8'hAA);
    @(negedge clk); drive(1, 2, 8'hBB);
    @(negedge clk); drive(0, 0, 0);
    chk("s4_block0", 32'(bus.valid0_o), 0);
    @(negedge clk);
    chk("s4_block2", 32'(bus.valid2_o), 0);
    bus.busy0_i = 0;
    @(negedge clk);
    chk("s4_valid0", 32'(bus.valid0_o), 1);
    chk("s4_data0", 32'(bus.data0_o), 32'hAA);
    chk("s4_v2_wait", 32'(bus.valid2_o), 0);
    @(negedge clk);
    chk("s4_valid2", 32'(bus.valid2_o), 1);
    chk("s4_data2", 32'(bus.data2_o), 32'hBB);

    // full FIFO: pop happens, simultaneous push ignored
    @(negedge clk); bus.busy0_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      drive(1, 0, 8'(8'h50 + i));
    end
    @(negedge clk);
    chk("s5_full", 32'(bus.busy_o), 1);
    bus.busy0_i = 0;
    drive(1, 0, 8'h99);
    @(negedge clk); drive(0, 0, 0);
    chk("s5_pop", 32'(bus.data0_o), 32'h50);
    chk("s5_count3", 32'(bus.busy_o), 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("s5_data0", 32'(bus.data0_o), 32'(8'h50 + i));
    end
    @(negedge clk);
    chk("s5_no_99", 32'(bus.valid0_o), 0);

    // async reset with entries queued
    @(negedge clk); bus.busy2_i = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      drive(1, 2, 8'(8'h60 + i));
    end
    @(negedge clk); drive(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_data0", 32'(bus.data0_o), 0);
    chk("s6_valid", 32'({bus.valid0_o, bus.valid1_o, bus.valid2_o}), 0);
    chk("s6_err", 32'(bus.err_o), 0);
    chk("s6_busy", 32'(bus.busy_o), 0);
    @(negedge clk); #1 rst_n = 1'b1; bus.busy2_i = 0;
    repeat (6) begin
      @(negedge clk);
      chk("s6_stale", 32'(bus.valid2_o), 0);
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
      end
      bus.busy0_i = ($urandom_range(0, 99) < 30);
      bus.busy1_i = ($urandom_range(0, 99) < 30);
      bus.busy2_i = ($urandom_range(0, 99) < 30);
      drive($urandom_range(0, 99) < 60,
            ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            8'($urandom_range(0, 255)));
    end
    @(negedge clk);
    drive(0, 0, 0);
    bus.busy0_i = 0;
    bus.busy1_i = 0;
    bus.busy2_i = 0;
    repeat (8) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decryption_demux.md
DECRYPTION_DEMUX -- requirements
Module: decryption_demux

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving the width of the data bus.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of buffer entries (power of two, at least 2).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port data_i, input, D_WIDTH bits: encrypted byte from the upstream source.
REQ-006 Port valid_i, input, 1 bit: data_i and select_i are valid this cycle.
REQ-007 Port select_i, input, 2 bits: target decryptor (0 = caesar, 1 = scytale, 2 = zigzag, 3 = illegal).
REQ-008 Ports busy0_i, busy1_i and busy2_i, inputs, 1 bit each: busy signal from decryptors 0, 1 and 2.
REQ-009 Ports data0_o, data1_o and data2_o, outputs, D_WIDTH bits each: registered data towards each decryptor.
REQ-010 Ports valid0_o, valid1_o and valid2_o, outputs, 1 bit each: registered one-cycle strobe for each channel.
REQ-011 Port busy_o, output, 1 bit: buffer full; upstream SHALL NOT present new data while it is high.
REQ-012 Port err_o, output, 1 bit: registered one-cycle pulse flagging an illegal select.

Function
REQ-013 The block SHALL hold a FIFO of FIFO_DEPTH entries, each storing {select, data}, with read and write pointers that wrap modulo FIFO_DEPTH.
REQ-014 busy_o SHALL equal (count == FIFO_DEPTH) and SHALL be decoded combinationally from registered state.
REQ-015 Push: at a rising edge where valid_i=1, busy_o=0 and select_i<3, the block SHALL write the entry at wptr and increment wptr.
REQ-016 At an edge where valid_i=1 and busy_o=1, the block SHALL ignore the input, leave state unchanged and drop the data silently.
REQ-017 At an edge where valid_i=1 and select_i=3, the block SHALL NOT push the entry and SHALL drive err_o to 1 for the following cycle only; this applies regardless of busy_o.
REQ-018 Pop: at a rising edge where count>0 and busy[head.select]=0, the block SHALL register head.data onto data<head.select>_o, set valid<head.select>_o=1 for exactly one cycle, and increment rptr.
REQ-019 Only one channel SHALL be popped per cycle.
REQ-020 Entries SHALL be delivered strictly in arrival order; a busy head channel SHALL stall all following entries (head-of-line blocking, no reordering).
REQ-021 When an output is not strobed, its valid SHALL return to 0, and its data SHALL hold its last value.
REQ-022 A push and a pop at the same edge SHALL both occur and leave count unchanged; this is allowed when the FIFO is full only if the pop happens, and busy_o still gates the push in that cycle.
REQ-023 Latency: with the FIFO empty and the target idle, data sampled at edge t SHALL appear with valid at edge t+2, i.e. one edge to push and one edge to pop.
REQ-024 Busy inputs SHALL be sampled at the pop edge; a busy rising in the same cycle as a head becoming ready SHALL block that pop.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force to 0: wptr, rptr, count, all valid*_o, all data*_o, err_o and busy_o; FIFO contents need not be cleared.
REQ-026 A reset asserted mid-operation SHALL discard all buffered entries; after rst_n rises, the first edge SHALL behave as if the FIFO were empty.

Verification
REQ-027 Scenario: reset, then push 0x41 with select=0 while busy0_i=0 -> data0_o=0x41 and valid0_o=1 for one cycle at t+2; valid1_o and valid2_o stay 0.
REQ-028 Scenario: hold busy1_i=1 and push five select=1 bytes 0x10..0x14 with valid held -> busy_o rises after the 4th push and 0x14 is dropped; after releasing busy1_i, 0x10..0x13 appear on channel 1 in order on consecutive cycles.
REQ-029 Scenario: push 0x22 with select=3 -> err_o=1 for one cycle, no valid on any channel, and count unchanged.
REQ-030 Scenario: with busy0_i=1 and entries (sel0,0xAA) then (sel2,0xBB) queued -> nothing is output; after releasing busy0_i, 0xAA appears on channel 0, then 0xBB on channel 2 one cycle later.
REQ-031 Scenario: with the FIFO full, present a new push in the same cycle the head's channel becomes free -> a pop occurs, the push is ignored because busy_o was 1, and count becomes 3.
REQ-032 Scenario: assert rst_n=0 asynchronously between clock edges with 3 entries queued -> all outputs go to 0 immediately, and after release no stale entry is ever output.
